// File: rtl/recording_player.sv
// Plays back a saved recording of {note, duration} words from one of three slots.
// Each word sounds for `duration` timebase ticks; a zero duration marks the end of the recording.
module recording_player #(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned DUR_W = 12
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               play,
    input  logic               stop,
    input  logic [1:0]         slot_sel,
    input  logic               tick,
    output logic [IDX_W+1:0]   rd_addr,
    input  logic [DUR_W+3:0]   rd_data,
    output logic [3:0]         note_out,
    output logic               note_valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {StIdle, StFetch, StLoad, StPlay, StDone} state_e;

    localparam logic [DUR_W-1:0] DurOne  = DUR_W'(1);
    localparam logic [IDX_W-1:0] IdxLast = {IDX_W{1'b1}};

    state_e           state_q;
    logic [1:0]       slot_q;
    logic [IDX_W-1:0] idx_q;
    logic [DUR_W-1:0] count_q;
    logic [3:0]       note_q;

    logic [3:0]       rd_note;
    logic [DUR_W-1:0] rd_dur;

    assign rd_note = rd_data[DUR_W+3:DUR_W];
    assign rd_dur  = rd_data[DUR_W-1:0];

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            slot_q  <= 2'd0;
            idx_q   <= '0;
            count_q <= '0;
            note_q  <= 4'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (play && !stop && (slot_sel != 2'd3)) begin
                        slot_q  <= slot_sel;
                        idx_q   <= '0;
                        state_q <= StFetch;
                    end
                end
                StFetch: begin
                    if (stop) begin
                        state_q <= StIdle;
                        note_q  <= 4'd0;
                    end else begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (stop) begin
                        state_q <= StIdle;
                        note_q  <= 4'd0;
                    end else if (rd_dur == '0) begin
                        state_q <= StDone;
                        note_q  <= 4'd0;
                    end else begin
                        note_q  <= rd_note;
                        count_q <= rd_dur;
                        state_q <= StPlay;
                    end
                end
                StPlay: begin
                    // Stop wins over a coincident tick: the count is left untouched.
                    if (stop) begin
                        state_q <= StIdle;
                        note_q  <= 4'd0;
                    end else if (tick) begin
                        count_q <= count_q - DurOne;
                        if (count_q == DurOne) begin
                            if (idx_q == IdxLast) begin
                                state_q <= StDone;
                                note_q  <= 4'd0;
                            end else begin
                                idx_q   <= idx_q + 1'b1;
                                state_q <= StFetch;
                            end
                        end
                    end
                end
                StDone: begin
                    note_q  <= 4'd0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    note_q  <= 4'd0;
                end
            endcase
        end
    end

    assign rd_addr    = {slot_q, idx_q};
    assign note_out   = note_q;
    assign note_valid = (state_q == StPlay) && (note_q != 4'd0);
    assign busy       = (state_q == StFetch) || (state_q == StLoad) || (state_q == StPlay);
    assign done       = (state_q == StDone);

endmodule

// File: tb/tb_recording_player.sv
// Bench for recording_player: directed table, corner-case sequences and a randomized run,
// all compared against a queue-free behavioural playback model.
module tb_recording_player;

    logic        clk = 1'b0;
    logic        resetn;
    logic        play;
    logic        stop;
    logic [1:0]  slot_sel;
    logic        tick;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic [3:0]  note_out;
    logic        note_valid;
    logic        busy;
    logic        done;

    logic [15:0] mem [256];

    int checks = 0;
    int errors = 0;

    // Model state: playback progress expressed as slot/entry/ticks-left plus fetch gap.
    bit m_busy, m_done;
    int m_gap, m_rem, m_idx, m_slot, m_note;

    recording_player #(.IDX_W(6), .DUR_W(12)) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .play       (play),
        .stop       (stop),
        .slot_sel   (slot_sel),
        .tick       (tick),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .note_out   (note_out),
        .note_valid (note_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Synchronous memory: word valid one cycle after its address.
    always @(posedge clk) rd_data <= mem[rd_addr];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_gap = 0; m_rem = 0; m_idx = 0; m_slot = 0; m_note = 0;
    endtask

    task automatic model_finish();
        m_busy = 0; m_done = 1; m_note = 0;
    endtask

    task automatic model_step(input bit p, input bit s, input bit [1:0] sl, input bit t);
        logic [15:0] w;
        if (m_done) begin
            m_done = 0;
        end else if (!m_busy) begin
            if (p && !s && sl != 2'd3) begin
                m_busy = 1; m_gap = 2; m_idx = 0; m_slot = int'(sl);
            end
        end else if (s) begin
            m_busy = 0; m_note = 0;
        end else if (m_gap == 2) begin
            m_gap = 1;
        end else if (m_gap == 1) begin
            w = mem[m_slot * 64 + m_idx];
            if (w[11:0] == 12'd0) model_finish();
            else begin
                m_note = int'(w[15:12]); m_rem = int'(w[11:0]); m_gap = 0;
            end
        end else if (t) begin
            if (m_rem > 1) m_rem--;
            else if (m_idx == 63) model_finish();
            else begin
                m_idx++; m_gap = 2;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rd_addr"}, int'(rd_addr), m_slot * 64 + m_idx);
        chk({tag, ".note_out"}, int'(note_out), m_note);
        chk({tag, ".note_valid"}, int'(note_valid), int'(m_busy && m_gap == 0 && m_note != 0));
        chk({tag, ".busy"}, int'(busy), int'(m_busy));
        chk({tag, ".done"}, int'(done), int'(m_done));
    endtask

    task automatic step(input bit p, input bit s, input bit [1:0] sl, input bit t,
                        input string tag);
        play = p; stop = s; slot_sel = sl; tick = t;
        @(posedge clk);
        model_step(p, s, sl, t);
        #1;
        check_all(tag);
    endtask

    typedef struct {
        bit         p;
        bit         s;
        bit [1:0]   sl;
        bit         t;
        bit         eb;
        bit         ed;
        logic [3:0] en;
        logic [7:0] ea;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int dones, n5, consumed, cyc;
        bit seen41, seen42, started;

        // Idle-rejects, then an empty slot-0 recording; the last play lands in DONE and is ignored.
        vecs[0] = '{p:1, s:0, sl:3, t:0, eb:0, ed:0, en:0, ea:8'h00};
        vecs[1] = '{p:1, s:1, sl:1, t:0, eb:0, ed:0, en:0, ea:8'h00};
        vecs[2] = '{p:1, s:0, sl:0, t:1, eb:1, ed:0, en:0, ea:8'h00};
        vecs[3] = '{p:1, s:0, sl:2, t:1, eb:1, ed:0, en:0, ea:8'h00};
        vecs[4] = '{p:0, s:0, sl:1, t:0, eb:0, ed:1, en:0, ea:8'h00};
        vecs[5] = '{p:1, s:0, sl:1, t:0, eb:0, ed:0, en:0, ea:8'h00};

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        resetn = 1'b0; play = 0; stop = 0; slot_sel = 0; tick = 0;
        model_reset();
        #12;
        check_all("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) resetn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            step(vecs[i].p, vecs[i].s, vecs[i].sl, vecs[i].t, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_busy", i), int'(busy), int'(vecs[i].eb));
            chk($sformatf("vec%0d.tbl_done", i), int'(done), int'(vecs[i].ed));
            chk($sformatf("vec%0d.tbl_note", i), int'(note_out), int'(vecs[i].en));
            chk($sformatf("vec%0d.tbl_addr", i), int'(rd_addr), int'(vecs[i].ea));
        end

        // Slot 1: note 5 for 3 ticks, rest for 2 ticks, end marker; tick every 4 cycles.
        mem[64] = 16'h5003; mem[65] = 16'h0002; mem[66] = 16'h0000;
        step(1, 0, 1, 0, "s1_play");
        dones = 0; n5 = 0; seen41 = 0; seen42 = 0; cyc = 0;
        while ((busy || done) && cyc < 200) begin
            if (cyc % 4 == 3 && note_valid && note_out == 4'd5) n5++;
            step(0, 0, 2'd2, cyc % 4 == 3, "s1_run");
            if (rd_addr == 8'h41) seen41 = 1;
            if (rd_addr == 8'h42) seen42 = 1;
            if (done) dones++;
            cyc++;
        end
        chk("s1_timeout", int'(cyc < 200), 1);
        chk("s1_note5_ticks", n5, 3);
        chk("s1_addr41", int'(seen41), 1);
        chk("s1_addr42", int'(seen42), 1);
        chk("s1_done_count", dones, 1);
        chk("s1_busy_after", int'(busy), 0);

        // Long note aborted by stop coinciding with a tick.
        mem[0] = 16'h7FFF;
        step(1, 0, 0, 0, "stop_play");
        cyc = 0;
        while (!note_valid && cyc < 10) begin
            step(0, 0, 0, 0, "stop_wait"); cyc++;
        end
        chk("stop_reached_play", int'(note_valid), 1);
        repeat (3) step(0, 0, 0, 1, "stop_ticks");
        step(0, 1, 0, 1, "stop_hit");
        chk("stop_busy", int'(busy), 0);
        chk("stop_note", int'(note_out), 0);
        step(0, 0, 0, 0, "stop_after");
        chk("stop_no_done", int'(done), 0);

        // Slot 2 fully populated: 64 one-tick notes, then DONE without refetching index 0.
        for (int i = 128; i < 192; i++) mem[i] = 16'h1001;
        step(1, 0, 2, 1, "full_play");
        consumed = 0; dones = 0; cyc = 0; started = 0;
        while ((busy || done) && cyc < 400) begin
            if (note_valid) consumed++;
            step(0, 0, 2'd1, 1, "full_run");
            if (rd_addr == 8'hBF) started = 1;
            if (started) chk("full_no_wrap", int'(rd_addr == 8'h80), 0);
            if (done) dones++;
            cyc++;
        end
        chk("full_timeout", int'(cyc < 400), 1);
        chk("full_ticks", consumed, 64);
        chk("full_done_count", dones, 1);

        // Asynchronous reset mid-note, then a clean restart from {slot,0}.
        step(1, 0, 1, 0, "rst_play");
        cyc = 0;
        while (!note_valid && cyc < 10) begin
            step(0, 0, 1, 0, "rst_wait"); cyc++;
        end
        chk("rst_reached_play", int'(note_valid), 1);
        @(negedge clk) resetn = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        @(negedge clk) resetn = 1'b1;
        step(0, 0, 1, 1, "rst_idle");
        step(1, 0, 1, 0, "rst_restart");
        chk("rst_restart_addr", int'(rd_addr), 8'h40);
        chk("rst_restart_busy", int'(busy), 1);

        // Randomized recordings and stimulus against the model.
        for (int i = 0; i < 192; i++) begin
            mem[i][15:12] = 4'($urandom_range(0, 15));
            mem[i][11:0]  = ($urandom_range(0, 9) == 0) ? 12'd0 : 12'($urandom_range(1, 3));
        end
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
                 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
